bram_arbiter: RTL

Two-requester arbiter that shares one single-port `BRAM` (1-cycle registered read, read-before-write) between a producer (e.g. sample/ring-buffer writer) and a consumer (e.g. MFCC frame reader). It sits between the two requesters and the RAM instance in the MFC_REC datapath.
- Grants one access per cycle, round-robin on conflict, with optional burst lock.
- Returns read data with a per-requester valid strobe.
- Counts denied request cycles for debug.

---
 rtl/mfc_bram_pkg.sv | 15 +
 rtl/bram_arbiter_rr_pick2.sv | 35 +++
 rtl/bram_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/mfc_bram_pkg.sv
// Shared constants for the two-requester BRAM arbiter.
// Requester IDs, lock-owner encodings and default RAM geometry.
package mfc_bram_pkg;

    localparam int DWIDTH_DEF = 40;
    localparam int AWIDTH_DEF = 9;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_R0   = 2'd1;
    localparam logic [1:0] OWN_R1   = 2'd2;

endpackage

// File: rtl/bram_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker with lock override.
// Ports: req[1:0], last, owner[1:0] in; one-hot-or-zero gnt[1:0] out.
module rr_pick2
    import mfc_bram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] owner,
    output logic [1:0] gnt
);

    logic hold0;
    logic hold1;

    assign hold0 = (owner == OWN_R0) && req[0];
    assign hold1 = (owner == OWN_R1) && req[1];

    // A lock whose holder dropped its request falls
    // through to normal selection in the same cycle.
    always_comb begin
        gnt = 2'b00;
        if (hold0) begin
            gnt = 2'b01;
        end else if (hold1) begin
            gnt = 2'b10;
        end else if (req == 2'b01) begin
            gnt = 2'b01;
        end else if (req == 2'b10) begin
            gnt = 2'b10;
        end else if (req == 2'b11) begin
            gnt = (last == REQ1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port BRAM between two requesters, one access/cycle.
// Ports: req/we/lock/addr/wdata per requester, gnt/rvalid, rdata, bram_*, conflict_cnt.
module bram_arbiter
    import mfc_bram_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int CWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic                     lock0,
    input  logic                     lock1,
    input  logic [AWIDTH-1:0]        addr0,
    input  logic [AWIDTH-1:0]        addr1,
    input  logic [DWIDTH-1:0]        wdata0,
    input  logic [DWIDTH-1:0]        wdata1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic signed [DWIDTH-1:0] rdata,
    output logic                     bram_write,
    output logic [AWIDTH-1:0]        bram_addr,
    output logic [DWIDTH-1:0]        bram_indata,
    input  logic signed [DWIDTH-1:0] bram_outdata,
    output logic [CWIDTH-1:0]        conflict_cnt
);

    logic              last;
    logic [1:0]        owner;
    logic [1:0]        rv_pend;
    logic [1:0]        pick;
    logic [1:0]        gnt;
    logic [AWIDTH-1:0] addr_q;

    rr_pick2 u_pick (
        .req   ({req1, req0}),
        .last  (last),
        .owner (owner),
        .gnt   (pick)
    );

    // Grants are suppressed while reset is held.
    assign gnt  = rst ? 2'b00 : pick;
    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    assign rvalid0 = rv_pend[0];
    assign rvalid1 = rv_pend[1];
    assign rdata   = bram_outdata;

    // Idle cycles park the address on the last granted one.
    always_comb begin
        bram_write  = 1'b0;
        bram_addr   = addr_q;
        bram_indata = wdata0;
        unique case (1'b1)
            gnt[0]: begin
                bram_write  = we0;
                bram_addr   = addr0;
                bram_indata = wdata0;
            end
            gnt[1]: begin
                bram_write  = we1;
                bram_addr   = addr1;
                bram_indata = wdata1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last    <= REQ1;
            owner   <= OWN_NONE;
            rv_pend <= 2'b00;
            addr_q  <= '0;
        end else if (gnt[0]) begin
            last    <= REQ0;
            owner   <= lock0 ? OWN_R0 : OWN_NONE;
            rv_pend <= {1'b0, ~we0};
            addr_q  <= addr0;
        end else if (gnt[1]) begin
            last    <= REQ1;
            owner   <= lock1 ? OWN_R1 : OWN_NONE;
            rv_pend <= {~we1, 1'b0};
            addr_q  <= addr1;
        end else begin
            owner   <= OWN_NONE;
            rv_pend <= 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (req0 && req1 && !(&conflict_cnt)) begin
            conflict_cnt <= conflict_cnt + CWIDTH'(1);
        end
    end

endmodule
